fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Parametrised program-flow controller for the core. It owns the program counter and the req/done run handshake, and resolves absolute or PC-relative jumps under flag conditions. It also holds the registered zero/parity/shift-carry flags, and counts run cycles. It sits between the control decoder and PC_LUT on one side, and instr_ROM on the other.

Parameters:
D, 12, program counter width.
START_ADDR, 0, PC value loaded on reset and on each accepted req.
HALT_ADDR, 128, fetch address that terminates a run.
CW, 16, cycle counter width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  1  start request; sampled in IDLE/DONE.
stall  in  1  hold PC and flags this cycle.
halt  in  1  decoded halt instruction at current PC.
br_en  in  1  jump/branch instruction at current PC.
br_mode  in  1  0 = absolute (br_target is address); 1 = relative (br_target is two's-complement offset).
br_cond  in  2  00 always, 01 zero_q=1, 10 zero_q=0, 11 pari_q=1.
br_target  in  D  from PC_LUT.
flag_en  in  1  capture zero_i/pari_i.
zero_i  in  1  ALU zero flag.
pari_i  in  1  ALU parity flag.
sc_i  in  1  ALU shift/carry out.
sc_en  in  1  capture sc_i.
sc_clr  in  1  clear sc_q.
prog_ctr  out  D  current fetch address.
busy  out  1  high in RUN.
done  out  1  high in DONE.
zero_q  out  1  registered zero flag.
pari_q  out  1  registered parity flag.
sc_q  out  1  registered shift/carry flag.
cycle_cnt  out  CW  RUN cycles of the current/last run.

Behaviour:
- Reset (reset=0, no clock needed): state=IDLE, prog_ctr=START_ADDR, busy=0, done=0, zero_q=pari_q=sc_q=0, cycle_cnt=0. All outputs are registered.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- IDLE/DONE with req=1: next cycle state=RUN, prog_ctr=START_ADDR, cycle_cnt=0, flags=0, done=0. With req=0: everything holds, and done stays high in DONE.
- RUN: req is ignored. cycle_cnt increments every RUN cycle, including stalled ones, and saturates at 2^CW-1.
- RUN next-PC priority, highest first:
  1. stall=1: prog_ctr and flags hold; halt, br_en and HALT_ADDR match are not acted on.
  2. halt=1 or prog_ctr==HALT_ADDR: next state=DONE, prog_ctr holds.
  3. taken=br_en & cond(br_cond, zero_q, pari_q): absolute gives prog_ctr<=br_target; relative gives prog_ctr<=prog_ctr+br_target mod 2^D.
  4. otherwise prog_ctr<=prog_ctr+1 mod 2^D (4095 wraps to 0 at D=12).
- Branch conditions use the registered flags (set by an earlier instruction), never same-cycle zero_i/pari_i.
- Flags update only in RUN with stall=0:
  - flag_en=1 loads zero_q<=zero_i and pari_q<=pari_i.
  - For sc_q, sc_clr takes priority over sc_en; sc_en=1 loads sc_i.
  - A flag write in the same cycle as a taken branch does not affect that branch's condition.
- The halting cycle counts in cycle_cnt; flag writes in the halting cycle still occur.
- Reset asserted mid-run returns immediately to reset values; the run is abandoned and done is not raised.
- Latency: req to first fetch is 1 cycle. Halting instruction to done=1 is 1 cycle.

Test Plan:
- Defaults. Reset, then 1-cycle req: next cycle busy=1, prog_ctr=0; PC steps 1,2,...,128. Cycle after PC=128: done=1, busy=0, prog_ctr=128, cycle_cnt=129. A second req gives prog_ctr=0, done=0, cycle_cnt=0.
- Jumps. At PC=5, br_en=1, br_mode=0, br_cond=00, br_target=40 -> next PC=40. At PC=40, br_mode=1, br_target=12'hFFC -> PC=36. Absolute jump to 4095 with no branch -> next PC=0.
- Conditional branch:
  - flag_en=1, zero_i=1 at PC=10, then br_en at PC=11 with br_cond=01, target=50 -> PC=50.
  - Same with zero_i=0 -> PC=12.
  - br_cond=10 with zero_q=0 -> taken.
  - br_cond=11 with pari_q=0 -> not taken.
- Priority and stall:
  - halt=1 and br_en=1 at PC=20 -> done=1, PC=20.
  - stall=1 with br_en=1 at PC=30 for 3 cycles -> PC stays 30, cycle_cnt +3, flags unchanged; branch resolves on the first unstalled cycle.
- sc flag:
  - sc_en=1, sc_i=1 -> sc_q=1.
  - sc_clr=1 and sc_en=1 with sc_i=1 -> sc_q=0.
  - sc_en while stalled -> no change.
- Async reset: drop reset mid-run at PC=77 between clock edges -> prog_ctr=0, busy=0, done=0, flags=0, cycle_cnt=0 immediately. Releasing reset gives IDLE until req.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, run handshake, branch resolution and flag registers
//
// Purpose: owns the fetch address for instr_ROM and the req/done run
// handshake. Absolute or PC-relative jumps are resolved against the
// registered zero/parity flags. Run cycles are counted with saturation.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   req                   start request, sampled in IDLE/DONE
//   stall                 hold PC and flags this cycle
//   halt, br_en           decoded halt / jump at the current PC
//   br_mode, br_cond      0 absolute / 1 relative; condition select
//   br_target             jump address or two's-complement offset
//   flag_en, zero_i, pari_i   capture ALU zero/parity flags
//   sc_i, sc_en, sc_clr   shift/carry capture and clear
//   prog_ctr              current fetch address
//   busy, done            RUN / DONE indicators
//   zero_q, pari_q, sc_q  registered flags
//   cycle_cnt             RUN cycles of the current/last run
module fetch_sequencer #(
  parameter int D          = 12,
  parameter int START_ADDR = 0,
  parameter int HALT_ADDR  = 128,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          halt,
  input  logic          br_en,
  input  logic          br_mode,
  input  logic [1:0]    br_cond,
  input  logic [D-1:0]  br_target,
  input  logic          flag_en,
  input  logic          zero_i,
  input  logic          pari_i,
  input  logic          sc_i,
  input  logic          sc_en,
  input  logic          sc_clr,
  output logic [D-1:0]  prog_ctr,
  output logic          busy,
  output logic          done,
  output logic          zero_q,
  output logic          pari_q,
  output logic          sc_q,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            zero_d, pari_d, sc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cond_ok;

  // Conditions look only at the registered flags, so a flag write in the
  // same cycle as a branch never influences that branch.
  always_comb begin
    cond_ok = 1'b0;
    case (br_cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = zero_q;
      2'b10:   cond_ok = ~zero_q;
      default: cond_ok = pari_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    pari_d  = pari_q;
    sc_d    = sc_q;

    case (state_q)
      S_RUN: begin
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
        if (!stall) begin
          if (flag_en) begin
            zero_d = zero_i;
            pari_d = pari_i;
          end
          if (sc_clr)     sc_d = 1'b0;
          else if (sc_en) sc_d = sc_i;

          if (halt || (pc_q == D'(HALT_ADDR))) begin
            state_d = S_DONE;
          end else if (br_en && cond_ok) begin
            // Relative offsets are two's complement; modular add covers both signs.
            pc_d = br_mode ? (pc_q + br_target) : br_target;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      default: begin
        if (req) begin
          state_d = S_RUN;
          pc_d    = D'(START_ADDR);
          cnt_d   = '0;
          zero_d  = 1'b0;
          pari_d  = 1'b0;
          sc_d    = 1'b0;
        end
      end
    endcase

    // Indicators are registered copies of the next state so every output is a flop.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= D'(START_ADDR);
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      pari_q  <= 1'b0;
      sc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      pari_q  <= pari_d;
      sc_q    <= sc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign prog_ctr  = pc_q;
  assign cycle_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a behavioural model
module tb_fetch_sequencer;

  localparam int D     = 12;
  localparam int CW    = 8;
  localparam int START = 0;
  localparam int HALTA = 128;
  localparam int CMAX  = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req = 1'b0, stall = 1'b0, halt = 1'b0, br_en = 1'b0, br_mode = 1'b0;
  logic [1:0]    br_cond = 2'b00;
  logic [D-1:0]  br_target = '0;
  logic          flag_en = 1'b0, zero_i = 1'b0, pari_i = 1'b0;
  logic          sc_i = 1'b0, sc_en = 1'b0, sc_clr = 1'b0;
  logic [D-1:0]  prog_ctr;
  logic          busy, done, zero_q, pari_q, sc_q;
  logic [CW-1:0] cycle_cnt;

  fetch_sequencer #(.D(D), .START_ADDR(START), .HALT_ADDR(HALTA), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .halt(halt),
    .br_en(br_en), .br_mode(br_mode), .br_cond(br_cond), .br_target(br_target),
    .flag_en(flag_en), .zero_i(zero_i), .pari_i(pari_i),
    .sc_i(sc_i), .sc_en(sc_en), .sc_clr(sc_clr),
    .prog_ctr(prog_ctr), .busy(busy), .done(done),
    .zero_q(zero_q), .pari_q(pari_q), .sc_q(sc_q), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integers and bits.
  bit m_run = 0, m_done = 0, m_z = 0, m_p = 0, m_s = 0;
  int m_pc = START, m_cnt = 0;

  typedef struct packed {
    logic [D-1:0]  pc;
    logic          busy;
    logic          done;
    logic          z;
    logic          p;
    logic          s;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];

  function automatic obs_t model_obs();
    obs_t o;
    o.pc   = D'(m_pc);
    o.busy = m_run;
    o.done = m_done;
    o.z    = m_z;
    o.p    = m_p;
    o.s    = m_s;
    o.cnt  = CW'(m_cnt);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pc = prog_ctr; o.busy = busy; o.done = done;
    o.z = zero_q; o.p = pari_q; o.s = sc_q; o.cnt = cycle_cnt;
    return o;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_z = 0; m_p = 0; m_s = 0; m_pc = START; m_cnt = 0;
  endtask

  // One clock of the program-flow rules applied to the current inputs.
  task automatic model_step();
    bit take;
    if (!m_run) begin
      if (req) begin
        m_run = 1; m_done = 0; m_pc = START; m_cnt = 0; m_z = 0; m_p = 0; m_s = 0;
      end
    end else begin
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (!stall) begin
        case (br_cond)
          2'b00:   take = 1;
          2'b01:   take = m_z;
          2'b10:   take = !m_z;
          default: take = m_p;
        endcase
        take = take && br_en;
        if (flag_en) begin m_z = zero_i; m_p = pari_i; end
        if (sc_clr) m_s = 0;
        else if (sc_en) m_s = sc_i;
        if (halt || m_pc == HALTA) begin
          m_run = 0; m_done = 1;
        end else if (take) begin
          m_pc = br_mode ? (m_pc + int'(br_target)) % 4096 : int'(br_target);
        end else begin
          m_pc = (m_pc + 1) % 4096;
        end
      end
    end
  endtask

  task automatic clear_inputs();
    req = 0; stall = 0; halt = 0; br_en = 0; br_mode = 0; br_cond = 2'b00; br_target = '0;
    flag_en = 0; zero_i = 0; pari_i = 0; sc_i = 0; sc_en = 0; sc_clr = 0;
  endtask

  // Called at a negedge with inputs already set: predict, queue, advance one cycle.
  task automatic step();
    model_step();
    exp_q.push_back(model_obs());
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (m_pc != target && m_run && guard < 5000) begin
      step();
      guard++;
    end
    checks++;
    if (m_pc != target || !m_run) begin
      errors++;
      $display("FAIL run_to: model pc=%0d run=%0d, required pc=%0d while running", m_pc, m_run, target);
    end
  endtask

  task automatic direct_check(input string name, input obs_t want);
    obs_t got;
    got = dut_obs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got pc=%0d busy=%0b done=%0b z=%0b p=%0b s=%0b cnt=%0d, required pc=%0d busy=%0b done=%0b z=%0b p=%0b s=%0b cnt=%0d",
               name, got.pc, got.busy, got.done, got.z, got.p, got.s, got.cnt,
               want.pc, want.busy, want.done, want.z, want.p, want.s, want.cnt);
    end
  endtask

  // Monitor: every sampled cycle with a pending prediction is compared.
  int mon_cyc = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t w, g;
        w = exp_q.pop_front();
        g = dut_obs();
        checks++;
        mon_cyc++;
        if (g !== w) begin
          errors++;
          $display("FAIL cyc%0d: got pc=%0d busy=%0b done=%0b z=%0b p=%0b s=%0b cnt=%0d, required pc=%0d busy=%0b done=%0b z=%0b p=%0b s=%0b cnt=%0d",
                   mon_cyc, g.pc, g.busy, g.done, g.z, g.p, g.s, g.cnt,
                   w.pc, w.busy, w.done, w.z, w.p, w.s, w.cnt);
        end
      end
    end
  end

  obs_t zero_obs;

  initial begin
    zero_obs = '0;
    zero_obs.pc = D'(START);
    #3;
    direct_check("reset_values", zero_obs);
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Straight-line run to HALT_ADDR, then restart.
    req = 1; step();
    for (int i = 0; i < 300 && m_run; i++) step();
    checks++;
    if (m_cnt != 129 || m_pc != 128) begin
      errors++;
      $display("FAIL model_first_run: cnt=%0d pc=%0d, required cnt=129 pc=128", m_cnt, m_pc);
    end
    step();
    req = 1; step();

    // Absolute, negative relative, and absolute to the top address then wrap.
    run_to(5);
    br_en = 1; br_target = 12'd40; step();
    br_en = 1; br_mode = 1; br_target = 12'hFFC; step();
    br_en = 1; br_target = 12'hFFF; step();
    step();

    // Conditional branches on registered flags.
    run_to(10);
    flag_en = 1; zero_i = 1; step();
    br_en = 1; br_cond = 2'b01; br_target = 12'd50; step();
    br_en = 1; br_target = 12'd10; step();
    flag_en = 1; zero_i = 0; step();
    br_en = 1; br_cond = 2'b01; br_target = 12'd50; step();
    br_en = 1; br_cond = 2'b10; br_target = 12'd60; flag_en = 1; zero_i = 1; step();
    br_en = 1; br_cond = 2'b11; br_target = 12'd90; step();

    // Halt beats branch.
    br_en = 1; br_target = 12'd20; step();
    halt = 1; br_en = 1; br_target = 12'd99; step();
    step();
    req = 1; step();

    // Stall holds PC and flags but still counts.
    run_to(30);
    for (int i = 0; i < 3; i++) begin
      stall = 1; br_en = 1; br_target = 12'd70; flag_en = 1; zero_i = 1; pari_i = 1;
      sc_en = 1; sc_i = 1; step();
    end
    br_en = 1; br_target = 12'd70; step();

    // Shift/carry flag.
    sc_en = 1; sc_i = 1; step();
    sc_clr = 1; sc_en = 1; sc_i = 1; step();
    sc_en = 1; sc_i = 1; step();
    stall = 1; sc_clr = 1; step();

    // Long stall to saturate the cycle counter.
    for (int i = 0; i < 280; i++) begin stall = 1; step(); end
    br_en = 1; br_target = 12'd0; step();

    // Async reset between edges at PC=77.
    run_to(77);
    #2 reset = 0;
    #1 direct_check("async_reset", zero_obs);
    model_reset();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++) step();
    req = 1; step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!m_run) begin
        req = ($urandom_range(0, 3) == 0);
        stall = $urandom_range(0, 1);
        halt = $urandom_range(0, 1);
      end else begin
        stall = ($urandom_range(0, 4) == 0);
        halt = ($urandom_range(0, 39) == 0);
        br_en = ($urandom_range(0, 5) == 0);
        req = $urandom_range(0, 1);
      end
      br_mode = $urandom_range(0, 1);
      br_cond = 2'($urandom_range(0, 3));
      br_target = br_mode ? D'($urandom_range(0, 4095)) : D'($urandom_range(0, 200));
      flag_en = $urandom_range(0, 1);
      zero_i = $urandom_range(0, 1);
      pari_i = $urandom_range(0, 1);
      sc_i = $urandom_range(0, 1);
      sc_en = $urandom_range(0, 1);
      sc_clr = ($urandom_range(0, 3) == 0);
      step();
    end

    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
